// File: rtl/soc_system_sw_pkg.sv
// Shared constants and types for the slide-switch debouncer.
// Per-bit FSM states and counter-width helper live here.
package soc_system_sw_pkg;

    localparam int SW_WIDTH            = 10;
    localparam int SW_DEBOUNCE_DEFAULT = 1000000;

    typedef enum logic {
        SW_IDLE  = 1'b0,
        SW_COUNT = 1'b1
    } sw_state_e;

    // Counter width for a given debounce length; never narrower than 1 bit.
    function automatic int sw_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/soc_system_sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer, persistence counter,
// IDLE/COUNT FSM and registered rise/fall pulses.
module soc_system_sw_debounce_bit
    import soc_system_sw_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = sw_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_out;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    sw_state_e        r_state;
    logic             w_diff;

    assign w_diff  = r_sync2 ^ r_out;
    assign o_level = r_out;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

    // Bring the asynchronous pad into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it persists for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SW_IDLE;
            r_cnt   <= '0;
            r_out   <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                SW_IDLE: begin
                    if (w_diff) begin
                        r_state <= SW_COUNT;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                SW_COUNT: begin
                    if (!w_diff) begin
                        r_state <= SW_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_out   <= r_sync2;
                        r_rise  <= r_sync2;
                        r_fall  <= ~r_sync2;
                        r_state <= SW_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= SW_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/soc_system_sw_debounce.sv
// Ten-bit slide-switch debouncer feeding the switch PIO in_port.
// Bits are independent; this level only gathers their outputs.
module soc_system_sw_debounce
    import soc_system_sw_pkg::*;
#(
    parameter int               WIDTH           = SW_WIDTH,
    parameter int               DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            soc_system_sw_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (RESET_VAL[g])
            ) u_bit (
                .clk     (clk),
                .reset_n (reset_n),
                .i_raw   (sw_raw[g]),
                .o_level (sw_out[g]),
                .o_rise  (sw_rise[g]),
                .o_fall  (sw_fall[g])
            );
        end
    endgenerate

    assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: doc/soc_system_sw_debounce.md
# soc_system_sw_debounce

Per-bit synchronizer and debouncer for the ten DE1-SoC slide switches, sitting directly upstream of the switch PIO's `in_port`. It converts raw, asynchronous, bouncing pad inputs into clean, `clk`-synchronous levels. It also produces one-cycle rise and fall pulses for local fabric consumers. The PIO then sees exactly one edge per physical flip.

## Interface
- `WIDTH`, 10: number of switch bits.
- `DEBOUNCE_CYCLES`, 1000000: cycles a new level must persist before acceptance (20 ms at 50 MHz); legal range ≥ 2.
- `RESET_VAL`, 0: value of `sw_out` and of the synchronizer flops during reset.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `sw_raw`  in  WIDTH  raw switch pads, asynchronous to `clk`.
- `sw_out`  out  WIDTH  debounced level; drives PIO `in_port`.
- `sw_rise`  out  WIDTH  one-cycle pulse when a bit of `sw_out` goes 0→1.
- `sw_fall`  out  WIDTH  one-cycle pulse when a bit of `sw_out` goes 1→0.
- `sw_changed`  out  1  OR of `sw_rise | sw_fall`, same cycle.

## Operation
- Each bit is fully independent. There is no shared counter and no cross-bit interaction.
- **Synchronizer:** two flops per bit, `sync1 <= sw_raw`, then `sync2 <= sync1`. Only `sync2` is used downstream.
- **Counter:** one per bit, width `$clog2(DEBOUNCE_CYCLES)`, unsigned. It never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- **Per-bit FSM, state IDLE** (`sync2 == sw_out`):
  - The counter is held at 0.
  - On the first edge where `sync2 != sw_out`, go to COUNT with count = 1.
- **Per-bit FSM, state COUNT:**
  - While `sync2 != sw_out` and count < `DEBOUNCE_CYCLES-1`: count increments.
  - If `sync2 == sw_out` (the bounce returned): go to IDLE, count = 0, no output change, no pulse.
  - If `sync2 != sw_out` and count == `DEBOUNCE_CYCLES-1`:
    - `sw_out <= sync2`.
    - `sw_rise` or `sw_fall` is asserted for that bit for exactly the next cycle.
    - Go to IDLE, count = 0.
- Only one pulse is possible per accepted transition. `sw_rise` and `sw_fall` are never asserted together on the same bit.
- **Reset (asynchronous, any time, including mid-count):**
  - `sync1`, `sync2`, `sw_out` = `RESET_VAL`.
  - Counters = 0, FSM = IDLE.
  - `sw_rise`, `sw_fall`, `sw_changed` = 0.
- **After reset release:** if the pad differs from `RESET_VAL`, a normal debounce runs. It ends with one rise/fall pulse, which is expected behaviour.

## Timing
- All outputs are registered; there is no combinational path from `sw_raw`. `sw_changed` is registered or is an OR of registered pulses.
- **Latency:** let `sw_raw` change before edge E0.
  - `sync1` updates at E0 and `sync2` at E1.
  - The count reaches k at E(1+k).
  - `sw_out` and the pulse update at E(DEBOUNCE_CYCLES+1).
  - Total: DEBOUNCE_CYCLES+2 edges from raw change to `sw_out` change.
- **Pulse width:** exactly 1 cycle. It is coincident with the first cycle of the new `sw_out` value.
- **Glitch rejection:** a `sync2` excursion lasting < DEBOUNCE_CYCLES cycles produces no output change.
- **Re-arm:** a new transition can be accepted DEBOUNCE_CYCLES cycles after the previous acceptance at the earliest.

## Structure
- **Package `soc_system_sw_pkg`:**
  - `SW_WIDTH = 10`.
  - `SW_DEBOUNCE_DEFAULT = 1000000`.
  - Per-bit FSM state enum `{SW_IDLE, SW_COUNT}`.
- **Sub-module `soc_system_sw_debounce_bit`:** one bit's synchronizer, counter, FSM and pulse registers. It is instantiated `WIDTH` times in a generate loop. The top level only concatenates the bit outputs and computes `sw_changed`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `WIDTH=10`.
- **Reset:** hold `reset_n=0`, `sw_raw=10'h3FF` → `sw_out=10'h000`, no pulses.
  - Release → at E6, `sw_out=10'h3FF`, `sw_rise=10'h3FF` for 1 cycle, `sw_changed=1` for 1 cycle.
- **Clean flip:** bit 0 raw 0→1 before E0, held → `sw_out[0]` rises at E5, `sw_rise[0]` is high for cycles E5–E6 only, and `sw_fall` stays 0.
- **Bounce:** bit 3 raw 0→1 for 3 cycles, then 0 → no change on `sw_out[3]`, no pulse.
  - Then raw 1 held → rise accepted 6 edges after the final stable change.
- **Simultaneous:** bits 2 and 7 fall together while bit 5 rises in the same cycle → all three `sw_out` bits update on the same edge, `sw_fall=10'h084`, `sw_rise=10'h020`.
- **Reset mid-count:** bit 9 raw 0→1, assert `reset_n=0` at E3 → `sw_out[9]=0` immediately and the counter is cleared.
  - Release with raw still 1 → full 6-edge latency from the release edge before `sw_out[9]` rises.
- **Re-arm:** after acceptance at E5, raw returns 0 at once → `sw_fall[0]` fires exactly DEBOUNCE_CYCLES+2 edges after the raw change, with no overlap with `sw_rise[0]`.
